fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: ADDR_W, 8, instruction-memory address width; PC width.
REQ-002 SHALL have ports `clk` (input, 1) and `reset` (input, 1); single clock, synchronous active-high reset, all state updated on rising `clk`.
REQ-003 SHALL have port `start`, input, 1: begin fetching from the current PC when idle.
REQ-004 SHALL have port `mem_addr`, output, ADDR_W: instruction-memory read address; always equals `pc`.
REQ-005 SHALL have port `mem_data`, input, 16: memory read data, valid one cycle after the address is presented (registered ROM).
REQ-006 SHALL have port `d_instr`, output, 16: instruction to the processor core.
REQ-007 SHALL have port `run`, output, 1: one-cycle issue strobe to the core.
REQ-008 SHALL have port `done`, input, 1: core completion pulse.
REQ-009 SHALL have port `d_out`, input, 16: core result, sampled when `done`=1.
REQ-010 SHALL have port `pc`, output, ADDR_W: current program counter.
REQ-011 SHALL have port `busy`, output, 1: high in every state except IDLE and HALT.
REQ-012 SHALL have port `halted`, output, 1: high in HALT.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, LATCH, ISSUE, EXEC, HALT.
- IDLE: `start`=1 -> FETCH; otherwise stay.
- FETCH: one cycle, address presented -> LATCH.
- LATCH: capture `mem_data` into the instruction register, then decode.
REQ-014 SHALL decode in LATCH with this priority:
- 16'hFFFF -> HALT, PC unchanged.
- Branch (REQ-019) -> FETCH.
- Else -> ISSUE.
REQ-015 SHALL in ISSUE drive `run`=1 for exactly one cycle, then go to EXEC.
- `d_instr` holds the instruction register from ISSUE until the next LATCH.
REQ-016 SHALL in EXEC wait for `done`=1; on that cycle it captures `d_out` into `last_result`, sets pc<=pc+1, and goes to FETCH.
- `done` in any other state SHALL be ignored.
REQ-017 SHALL wrap PC modulo 2^ADDR_W (8'hFF+1 -> 8'h00) with no flag.
REQ-018 SHALL ignore `start` outside IDLE.
- HALT is left only by reset.
- Fetch-to-issue latency: 3 cycles (FETCH, LATCH, ISSUE).
REQ-019 Branch (macro enabled only): instr[1:0]==2'b10; cond=instr[3:2]; target=instr[4+ADDR_W-1:4].
- cond 00: taken if last_result==0.
- cond 01: taken if last_result!=0.
- cond 10: taken if last_result[15]==1.
- cond 11: always taken.
- Taken: pc<=target. Not taken: pc<=pc+1.
- A branch never asserts `run`; resolves in LATCH, so branch cost is 2 cycles.
REQ-020 SHALL evaluate a branch against `last_result` including a value captured on the immediately preceding `done`.

Reset
REQ-021 SHALL on `reset`=1 go to IDLE with pc=0, `d_instr`=0, instruction register=0, `last_result`=0, `run`=0, `busy`=0, `halted`=0.
- Reset overrides all inputs, including mid-EXEC; a `done` arriving in the reset cycle SHALL be discarded.

Configuration
REQ-022 SHALL support macro FETCH_BRANCH_EN.
- Defined: REQ-019/020 active.
- Undefined: no branch decode; every non-halt instruction is issued to the core, `last_result` logic may be omitted, pc always increments.

Verification
REQ-023 Reset, pulse `start`, mem[0]=16'h1234 -> `run` high in cycle 3 after `start` with `d_instr`=16'h1234; `done` 4 cycles later -> pc=1, FETCH next.
REQ-024 mem[0]=16'hFFFF, `start` -> `halted`=1, `busy`=0, pc=0, `run` never asserted; further `start` ignored until reset.
REQ-025 pc=8'hFF, normal instruction completes -> pc=8'h00.
REQ-026 FETCH_BRANCH_EN, `d_out`=0 at prior `done`, mem[1]=branch cond 00 target 8'h40 -> pc=8'h40, no `run`; with `d_out`=16'h0005 -> pc=2.
REQ-027 cond 10 with `d_out`=16'h8000 -> taken; cond 11 -> always taken regardless of `last_result`.
REQ-028 Reset asserted while in EXEC with `done`=1 same cycle -> IDLE, pc=0, `last_result`=0, `run`=0 next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer: fetch, latch/decode, issue, wait for core completion.
// Optional conditional/unconditional branch resolution in LATCH is enabled by `define FETCH_BRANCH_EN.
module fetch_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic [15:0]       d_instr,
  output logic              run,
  input  logic              done,
  input  logic [15:0]       d_out,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t      state;
  logic [15:0] ir;

  assign mem_addr = pc;
  // The instruction register only changes in LATCH, so it already holds from ISSUE to the next LATCH.
  assign d_instr  = ir;

`ifdef FETCH_BRANCH_EN
  logic [15:0] last_result;
  logic        taken;

  always_comb begin
    taken = 1'b0;
    case (mem_data[3:2])
      2'b00:   taken = (last_result == 16'h0000);
      2'b01:   taken = (last_result != 16'h0000);
      2'b10:   taken = last_result[15];
      default: taken = 1'b1;
    endcase
  end
`else
  logic unused_d_out;
  assign unused_d_out = ^d_out;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= '0;
      run         <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
`ifdef FETCH_BRANCH_EN
      last_result <= '0;
`endif
    end else begin
      run <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          state <= S_LATCH;
        end
        S_LATCH: begin
          ir <= mem_data;
          if (mem_data == 16'hFFFF) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end
`ifdef FETCH_BRANCH_EN
          else if (mem_data[1:0] == 2'b10) begin
            state <= S_FETCH;
            pc    <= taken ? mem_data[4+ADDR_W-1:4] : pc + 1'b1;
          end
`endif
          else begin
            state <= S_ISSUE;
            run   <= 1'b1;
          end
        end
        S_ISSUE: begin
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (done) begin
`ifdef FETCH_BRANCH_EN
            last_result <= d_out;
`endif
            pc    <= pc + 1'b1;
            state <= S_FETCH;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit with a registered ROM model.
// Branch vectors are compiled in when FETCH_BRANCH_EN is defined.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data = 16'h0000;
  logic [15:0] d_instr;
  logic        run;
  logic        done = 1'b0;
  logic [15:0] d_out = 16'h0000;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;

  logic [15:0] mem [256];
  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_addr(mem_addr), .mem_data(mem_data),
    .d_instr(d_instr), .run(run), .done(done), .d_out(d_out), .pc(pc), .busy(busy),
    .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic init_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0001;
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Called at a negedge; returns cycles waited until run is seen (bounded).
  task automatic wait_run(output int n);
    n = 0;
    while (!run && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  // From the ISSUE negedge: move into EXEC, then complete with the given core result.
  task automatic finish_exec(input logic [15:0] v);
    @(negedge clk);
    done = 1'b1;
    d_out = v;
    @(negedge clk);
    done = 1'b0;
  endtask

  // Watch up to n cycles for HALT, recording whether run pulsed meanwhile.
  task automatic wait_halt(input int n, output logic saw_run);
    saw_run = 1'b0;
    for (int i = 0; i < n && !halted; i++) begin
      @(negedge clk);
      if (run) saw_run = 1'b1;
    end
  endtask

`ifdef FETCH_BRANCH_EN
  task automatic br_case(input string tag, input logic [15:0] br, input logic [15:0] dv,
                         input logic [7:0] exp_pc);
    int n;
    logic saw;
    init_mem();
    mem[1] = br;
    mem[2] = 16'hFFFF;
    mem[8'h40] = 16'hFFFF;
    do_reset();
    pulse_start();
    wait_run(n);
    check({tag, "_run0"}, run, 1'b1);
    finish_exec(dv);
    wait_halt(20, saw);
    check({tag, "_halt"}, halted, 1'b1);
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_norun"}, saw, 1'b0);
  endtask
`endif

  initial begin
    int n;
    logic saw;

    init_mem();
    mem[0] = 16'h1234;
    mem[1] = 16'hFFFF;
    do_reset();
    check("rst_pc", pc, 8'h00);
    check("rst_addr", mem_addr, 8'h00);
    check("rst_dinstr", d_instr, 16'h0000);
    check("rst_run", run, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_halted", halted, 1'b0);

    // Basic fetch/issue/complete.
    pulse_start();
    check("fetch_busy", busy, 1'b1);
    wait_run(n);
    check("issue_latency", n + 1, 3);
    check("issue_run", run, 1'b1);
    check("issue_dinstr", d_instr, 16'h1234);
    @(negedge clk);
    check("exec_run_low", run, 1'b0);
    repeat (3) @(negedge clk);
    check("exec_pc_hold", pc, 8'h00);
    done = 1'b1;
    d_out = 16'h0005;
    @(negedge clk);
    done = 1'b0;
    check("done_pc", pc, 8'h01);
    check("done_addr", mem_addr, 8'h01);
    check("done_busy", busy, 1'b1);
    @(negedge clk);
    check("done_next_fetch_run", run, 1'b0);
    wait_halt(10, saw);
    check("halt1_pc", pc, 8'h01);
    check("halt1_dinstr_hold", d_instr, 16'hFFFF);

    // Halt on the very first word; start is then ignored.
    init_mem();
    mem[0] = 16'hFFFF;
    do_reset();
    pulse_start();
    wait_halt(10, saw);
    check("halt_flag", halted, 1'b1);
    check("halt_busy", busy, 1'b0);
    check("halt_pc", pc, 8'h00);
    check("halt_norun", saw, 1'b0);
    pulse_start();
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (run) saw = 1'b1;
    end
    check("halt_sticky", halted, 1'b1);
    check("halt_sticky_busy", busy, 1'b0);
    check("halt_sticky_pc", pc, 8'h00);
    check("halt_sticky_norun", saw, 1'b0);

    // PC wrap after 256 completed instructions.
    init_mem();
    do_reset();
    pulse_start();
    for (int i = 0; i < 256; i++) begin
      wait_run(n);
      if (!run) begin
        check("wrap_run_timeout", run, 1'b1);
        break;
      end
      finish_exec(16'h0001);
      if (i == 254) check("wrap_pc_ff", pc, 8'hFF);
      if (i == 255) check("wrap_pc_00", pc, 8'h00);
    end

    // Reset during EXEC with a coincident done.
    init_mem();
    mem[0] = 16'h0402;
    mem[8'h40] = 16'hFFFF;
`ifndef FETCH_BRANCH_EN
    mem[0] = 16'h0001;
`endif
    do_reset();
`ifdef FETCH_BRANCH_EN
    pulse_start();
    wait_run(n);
    check("pre_rst_run", run, 1'b0);
    wait_halt(20, saw);
    mem[0] = 16'h0001;
    do_reset();
`endif
    pulse_start();
    wait_run(n);
    check("midexec_run", run, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    done = 1'b1;
    d_out = 16'h0005;
    @(negedge clk);
    reset = 1'b0;
    done = 1'b0;
    check("midexec_pc", pc, 8'h00);
    check("midexec_run_low", run, 1'b0);
    check("midexec_busy", busy, 1'b0);
    check("midexec_dinstr", d_instr, 16'h0000);
    repeat (3) @(negedge clk);
    check("midexec_idle_pc", pc, 8'h00);
    check("midexec_idle_busy", busy, 1'b0);
`ifdef FETCH_BRANCH_EN
    // last_result must be 0 after reset: cond 00 branch is taken.
    mem[0] = 16'h0402;
    pulse_start();
    wait_halt(20, saw);
    check("midexec_lr_pc", pc, 8'h40);
    check("midexec_lr_norun", saw, 1'b0);

    br_case("c00_zero", 16'h0402, 16'h0000, 8'h40);
    br_case("c00_nz", 16'h0402, 16'h0005, 8'h02);
    br_case("c01_nz", 16'h0406, 16'h0005, 8'h40);
    br_case("c01_zero", 16'h0406, 16'h0000, 8'h02);
    br_case("c10_neg", 16'h040A, 16'h8000, 8'h40);
    br_case("c10_pos", 16'h040A, 16'h7FFF, 8'h02);
    br_case("c11_any", 16'h040E, 16'h0005, 8'h40);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
